// File: rtl/ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ctrl_pkg : shared types and encodings for the multicycle controller   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    R_EXE  = 4'd2,
    I_EXE  = 4'd3,
    B_EXE  = 4'd4,
    LU_EXE = 4'd5,
    AU_EXE = 4'd6,
    J_EXE  = 4'd7,
    JL_EXE = 4'd8,
    S_EXE  = 4'd9,
    S_MEM  = 4'd10,
    L_EXE  = 4'd11,
    L_MEM  = 4'd12,
    L_WB   = 4'd13,
    TRAP   = 4'd14
  } state_e;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  localparam logic [3:0] c_ALU_ADD = 4'b0000;

  localparam logic [2:0] c_RAM_WORD   = 3'b000;
  localparam logic [2:0] c_RAM_BYTE   = 3'b001;
  localparam logic [2:0] c_RAM_HALF   = 3'b010;
  localparam logic [2:0] c_RAM_BYTE_U = 3'b101;
  localparam logic [2:0] c_RAM_HALF_U = 3'b110;

  localparam logic [2:0] c_RFWD_ALU   = 3'd0;
  localparam logic [2:0] c_RFWD_LOAD  = 3'd1;
  localparam logic [2:0] c_RFWD_LUI   = 3'd2;
  localparam logic [2:0] c_RFWD_AUIPC = 3'd3;
  localparam logic [2:0] c_RFWD_PC4   = 3'd4;

  function automatic logic [2:0] store_ram_ctrl(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return c_RAM_BYTE;
      3'b001:  return c_RAM_HALF;
      default: return c_RAM_WORD;
    endcase
  endfunction

  function automatic logic [2:0] load_ram_ctrl(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return c_RAM_BYTE;
      3'b001:  return c_RAM_HALF;
      3'b100:  return c_RAM_BYTE_U;
      3'b101:  return c_RAM_HALF_U;
      default: return c_RAM_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_watchdog.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ctrl_watchdog : counts not-ready cycles and flags a bus timeout       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ctrl_watchdog #(
  parameter int BUS_TIMEOUT = 16,
  parameter int WAIT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic ready,
  input  logic stateChange,
  output logic timeout
);

  logic [WAIT_W-1:0] r_waitCnt;

  always_ff @(posedge clk) begin
    if (reset || !waiting || ready || stateChange) begin
      r_waitCnt <= '0;
    end else begin
      r_waitCnt <= r_waitCnt + WAIT_W'(1);
    end
  end

  // A ready in the firing cycle masks the timeout.
  generate
    if (BUS_TIMEOUT != 0) begin : g_wd_on
      localparam logic [WAIT_W-1:0] c_LIMIT = WAIT_W'(BUS_TIMEOUT - 1);
      assign timeout = waiting && !ready && (r_waitCnt == c_LIMIT);
    end else begin : g_wd_off
      assign timeout = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_hs.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multicycle_ctrl_hs : RV32I multicycle control FSM with handshakes     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module multicycle_ctrl_hs
  import ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int WAIT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             imemReady,
  input  logic             busReady,
  output logic             imemReq,
  output logic             busReq,
  output logic             regFileWe,
  output logic             PCEn,
  output logic [3:0]       aluControl,
  output logic             aluSrcMuxSel,
  output logic             busWe,
  output logic [2:0]       RFWDSrcMuxSel,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic [2:0]       ramControl,
  output logic             illegalInstr,
  output logic             busError,
  output logic [CNT_W-1:0] instretCount
);

  state_e            r_state;
  state_e            w_next;
  logic              r_illegal;
  logic              r_busErr;
  logic [CNT_W-1:0]  r_instret;
  logic              w_setIllegal;
  logic              w_waiting;
  logic              w_ready;
  logic              w_timeout;
  logic              w_retire;
  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic              w_i30;
  logic              w_unused;

  assign w_opcode = instrCode[6:0];
  assign w_funct3 = instrCode[14:12];
  assign w_i30    = instrCode[30];
  assign w_unused = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign w_waiting = (r_state == FETCH) || (r_state == S_MEM) || (r_state == L_MEM);
  assign w_ready   = (r_state == FETCH) ? imemReady : busReady;
  // DECODE and TRAP never return to FETCH, so any other entry is a retire.
  assign w_retire  = (r_state != FETCH) && (w_next == FETCH);

  ctrl_watchdog #(
    .BUS_TIMEOUT (BUS_TIMEOUT),
    .WAIT_W      (WAIT_W)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .waiting     (w_waiting),
    .ready       (w_ready),
    .stateChange (w_next != r_state),
    .timeout     (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
      r_busErr  <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_setIllegal) r_illegal <= 1'b1;
      if (w_timeout)    r_busErr  <= 1'b1;
      if (w_retire)     r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_setIllegal  = 1'b0;
    imemReq       = 1'b0;
    busReq        = 1'b0;
    regFileWe     = 1'b0;
    PCEn          = 1'b0;
    aluControl    = c_ALU_ADD;
    aluSrcMuxSel  = 1'b0;
    busWe         = 1'b0;
    RFWDSrcMuxSel = c_RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    ramControl    = c_RAM_WORD;
    case (r_state)
      FETCH: begin
        imemReq = 1'b1;
        PCEn    = imemReady;
        if (imemReady)      w_next = DECODE;
        else if (w_timeout) w_next = TRAP;
      end
      DECODE: begin
        case (w_opcode)
          OP_TYPE_R:  w_next = R_EXE;
          OP_TYPE_I:  w_next = I_EXE;
          OP_TYPE_L:  w_next = L_EXE;
          OP_TYPE_S:  w_next = S_EXE;
          OP_TYPE_B:  w_next = B_EXE;
          OP_TYPE_LU: w_next = LU_EXE;
          OP_TYPE_AU: w_next = AU_EXE;
          OP_TYPE_J:  w_next = J_EXE;
          OP_TYPE_JL: w_next = JL_EXE;
          default: begin
            w_next       = TRAP;
            w_setIllegal = 1'b1;
          end
        endcase
      end
      R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = {w_i30, w_funct3};
        w_next     = FETCH;
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // Only the shift-right immediates carry an op bit in instr[30].
        aluControl   = (w_funct3 == 3'b101) ? {w_i30, w_funct3} : {1'b0, w_funct3};
        w_next       = FETCH;
      end
      B_EXE: begin
        branch     = 1'b1;
        aluControl = {w_i30, w_funct3};
        w_next     = FETCH;
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = c_RFWD_LUI;
        w_next        = FETCH;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = c_RFWD_AUIPC;
        w_next        = FETCH;
      end
      J_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = c_RFWD_PC4;
        jal           = 1'b1;
        w_next        = FETCH;
      end
      JL_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = c_RFWD_PC4;
        jal           = 1'b1;
        jalr          = 1'b1;
        w_next        = FETCH;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        w_next       = S_MEM;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busReq       = 1'b1;
        busWe        = 1'b1;
        ramControl   = store_ram_ctrl(w_funct3);
        if (busReady)       w_next = FETCH;
        else if (w_timeout) w_next = TRAP;
      end
      L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = c_RFWD_LOAD;
        w_next        = L_MEM;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = c_RFWD_LOAD;
        busReq        = 1'b1;
        ramControl    = load_ram_ctrl(w_funct3);
        if (busReady)       w_next = L_WB;
        else if (w_timeout) w_next = TRAP;
      end
      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = c_RFWD_LOAD;
        ramControl    = load_ram_ctrl(w_funct3);
        w_next        = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = FETCH;
    endcase
  end

  assign illegalInstr = r_illegal;
  assign busError     = r_busErr;
  assign instretCount = r_instret;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl_hs.md
Name: multicycle_ctrl_hs

Overview:
Next-generation RV32I multicycle control FSM. It drives the same datapath control set as the current fixed-latency unit, and adds four things:
- ready/valid handshakes on instruction fetch and on data-bus access, so memories with wait states are supported;
- a parametrised bus-timeout watchdog;
- an illegal-opcode trap state;
- a retired-instruction counter.

It sits between the instruction register / datapath and the instruction and data memory interfaces.

Parameters:
BUS_TIMEOUT, 16, max cycles waiting for a ready signal before trap; 0 disables the watchdog.
CNT_W, 32, width of the retired-instruction counter.
WAIT_W, 8, width of the wait counter; BUS_TIMEOUT must be < 2**WAIT_W.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instrCode  in  32  current instruction (instruction register output)
imemReady  in  1  instruction memory has data this cycle
busReady  in  1  data bus completes the access this cycle
imemReq  out  1  instruction fetch request
busReq  out  1  data bus access request
regFileWe  out  1  register-file write enable
PCEn  out  1  PC update enable
aluControl  out  4  ALU op, {instr[30], funct3}; ADD = 4'b0000
aluSrcMuxSel  out  1  1 = immediate operand
busWe  out  1  data bus write
RFWDSrcMuxSel  out  3  0 ALU, 1 load data, 2 LUI imm, 3 AUIPC, 4 PC+4
branch, jal, jalr  out  1 each  PC-select controls
ramControl  out  3  000 word, 001 byte, 010 half, 101 byte unsigned, 110 half unsigned
illegalInstr  out  1  unknown opcode trapped
busError  out  1  watchdog timeout trapped
instretCount  out  CNT_W  retired instructions

Behaviour:
- **Clocking and reset.** All state changes on posedge clk. While reset=1, on the clock edge:
  - state <= FETCH;
  - waitCnt, instretCount, illegalInstr and busError <= 0.
- **Output decoding.** All outputs are combinational from state (Moore), except:
  - PCEn in FETCH, which equals imemReady;
  - busReq/busWe/ramControl, which follow the table below.
  - Default for every control output is 0; aluControl defaults to ADD.
- **States:** FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP.
- **FETCH**
  - Outputs: imemReq=1, PCEn=imemReady.
  - imemReady=1 → DECODE; otherwise stay in FETCH.
- **DECODE:** transition on opcode:
  - 0110011 → R_EXE
  - 0010011 → I_EXE
  - 0000011 → L_EXE
  - 0100011 → S_EXE
  - 1100011 → B_EXE
  - 0110111 → LU_EXE
  - 0010111 → AU_EXE
  - 1101111 → J_EXE
  - 1100111 → JL_EXE
  - any other → TRAP, with illegalInstr set.
- **Single-cycle execute states (→ FETCH):**
  - R_EXE: regFileWe=1, aluControl={i30,f3}.
  - I_EXE: regFileWe=1, aluSrc=1; aluControl={i30,f3} if f3=101, else {0,f3}.
  - B_EXE: branch=1, aluControl={i30,f3}.
  - LU_EXE: regFileWe=1, RFWD=2.
  - AU_EXE: regFileWe=1, RFWD=3.
  - J_EXE: regFileWe=1, RFWD=4, jal=1.
  - JL_EXE: regFileWe=1, RFWD=4, jal=1, jalr=1.
- **Stores**
  - S_EXE: aluSrc=1; → S_MEM.
  - S_MEM: aluSrc=1, busReq=1, busWe=1.
  - ramControl by funct3: 000 → 001, 001 → 010, else 000.
  - Hold in S_MEM until busReady=1, then → FETCH.
- **Loads**
  - L_EXE: aluSrc=1, RFWD=1; → L_MEM.
  - L_MEM: aluSrc=1, RFWD=1, busReq=1.
  - ramControl by funct3: 000 → 001, 001 → 010, 100 → 101, 101 → 110, else 000.
  - Hold in L_MEM until busReady=1, then → L_WB.
  - L_WB: regFileWe=1, aluSrc=1, RFWD=1, ramControl held from funct3; → FETCH.
- **Watchdog**
  - waitCnt increments in FETCH, S_MEM and L_MEM whenever the respective ready is 0.
  - waitCnt clears on ready=1 and on any state change.
  - If BUS_TIMEOUT≠0 and waitCnt==BUS_TIMEOUT-1 with ready still 0: → TRAP with busError set.
  - BUS_TIMEOUT=1 therefore traps on the first not-ready cycle.
- **Retire counting**
  - instretCount += 1 (wraps modulo 2**CNT_W) on every transition into FETCH from an execute, S_MEM or L_WB state.
  - The transition TRAP→FETCH does not exist.
- **TRAP**
  - All controls are 0; PCEn=0, regFileWe=0, busWe=0.
  - illegalInstr/busError are held.
  - TRAP is exited only by reset.
- **Boundary conditions**
  - Ready arriving in the same cycle the timeout would fire: ready wins, no trap.
  - Reset mid-S_MEM drops busWe/busReq on the next cycle; no partial retire is counted.

Decomposition:
- Package ctrl_pkg holds:
  - the state_e enum;
  - opcode constants (OP_TYPE_R … OP_TYPE_JL);
  - ALU op constants;
  - the ramControl encodings;
  - the RFWD select constants.
- One sub-module, ctrl_watchdog, holds waitCnt and the timeout compare (inputs: waiting, ready, stateChange; output: timeout).

Test Plan:
1. add x3,x1,x2 (0x002081B3), imemReady=1 → states FETCH, DECODE, R_EXE, FETCH; regFileWe=1 only in R_EXE; aluControl=0000; instretCount 0→1.
2. lw with busReady held low 3 cycles, BUS_TIMEOUT=16 → busReq=1 for 4 L_MEM cycles, ramControl=000, then L_WB with regFileWe=1; no busError.
3. sb, BUS_TIMEOUT=4, busReady stuck 0 → after 4 S_MEM cycles busError=1, state TRAP, busWe=0 thereafter; ready arriving on cycle 4 instead → no trap.
4. Opcode 0x0000007F → DECODE→TRAP, illegalInstr=1, PCEn stays 0 for 20 cycles; reset clears it and FETCH resumes.
5. srai (f3=101, i30=1) → aluControl=1101; slli-style f3=001 with i30=1 → aluControl=0001.
6. CNT_W=4: retire 17 instructions → instretCount=1 (wrap); reset asserted in S_MEM → next cycle FETCH, count 0.
